// File: rtl/float_pkg.sv
// Shared constants, state encoding and NaN helper for the float pipeline units.
package float_pkg;

  localparam logic [31:0] FP_QNAN      = 32'hFFC0_0000;
  localparam logic [7:0]  FP_EXP_MAX   = 8'hFF;
  localparam logic [31:0] FP_SIGN_MASK = 32'h8000_0000;

  localparam logic [3:0] ST_GET_P   = 4'd0;
  localparam logic [3:0] ST_GET_L   = 4'd1;
  localparam logic [3:0] ST_UNPACK  = 4'd2;
  localparam logic [3:0] ST_COMPARE = 4'd3;
  localparam logic [3:0] ST_PUT_Z   = 4'd4;

  typedef enum logic [3:0] {
    S_GET_P   = ST_GET_P,
    S_GET_L   = ST_GET_L,
    S_UNPACK  = ST_UNPACK,
    S_COMPARE = ST_COMPARE,
    S_PUT_Z   = ST_PUT_Z
  } state_t;

  function automatic logic fp_is_nan(input logic [31:0] bits);
    return (bits[30:23] == FP_EXP_MAX) && (bits[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/float_order_key.sv
// Maps a binary32 pattern to an unsigned key whose integer order matches float order.
module float_order_key
  import float_pkg::*;
(
  input  logic [31:0] value_i,
  output logic [31:0] key_o
);

  logic [31:0] canon;

  // -0 folds onto +0 so both zeros share one key
  assign canon = (value_i[30:0] == 31'd0) ? 32'd0 : value_i;
  assign key_o = canon[31] ? ~canon : (canon | FP_SIGN_MASK);

endmodule

// File: rtl/float_clamp.sv
// Handshaked binary32 clamp: z = clamp(p, -|l|, +|l|) with an out-of-range flag.
// state     | meaning
// GET_P     | wait for coordinate p
// GET_L     | wait for half-extent l (sign dropped)
// UNPACK    | register order keys and NaN flag
// COMPARE   | select result, raise output strobe
// PUT_Z     | hold result until consumer acks
module float_clamp
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_p,
  input  logic        input_p_stb,
  output logic        input_p_ack,
  input  logic [31:0] input_l,
  input  logic        input_l_stb,
  output logic        input_l_ack,
  output logic [31:0] output_z,
  output logic        output_clipped,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  state_t      state_q;
  logic [31:0] p_q;
  logic [31:0] l_q;
  logic [31:0] key_p_q;
  logic [31:0] key_l_q;
  logic [31:0] key_nl_q;
  logic        nan_q;
  logic        p_ack_q;
  logic        l_ack_q;
  logic        z_stb_q;
  logic [31:0] z_q;
  logic        clipped_q;

  logic [31:0] key_p_d;
  logic [31:0] key_l_d;
  logic [31:0] key_nl_d;
  logic        nan_d;
  logic [31:0] z_d;
  logic        clipped_d;

  float_order_key u_key_p (
    .value_i (p_q),
    .key_o   (key_p_d)
  );

  float_order_key u_key_l (
    .value_i (l_q),
    .key_o   (key_l_d)
  );

  // key(-|l|) is the complement of key(|l|), except that -0 canonicalises to +0
  assign key_nl_d = (l_q[30:0] == 31'd0) ? FP_SIGN_MASK : ~key_l_d;
  assign nan_d    = fp_is_nan(p_q) || fp_is_nan(l_q);

  always_comb begin
    z_d       = p_q;
    clipped_d = 1'b0;
    if (nan_q) begin
      z_d = FP_QNAN;
    end else if (key_p_q > key_l_q) begin
      z_d       = l_q;
      clipped_d = 1'b1;
    end else if (key_p_q < key_nl_q) begin
      z_d       = l_q | FP_SIGN_MASK;
      clipped_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_GET_P;
      p_q       <= 32'd0;
      l_q       <= 32'd0;
      key_p_q   <= 32'd0;
      key_l_q   <= 32'd0;
      key_nl_q  <= 32'd0;
      nan_q     <= 1'b0;
      p_ack_q   <= 1'b0;
      l_ack_q   <= 1'b0;
      z_stb_q   <= 1'b0;
      z_q       <= 32'd0;
      clipped_q <= 1'b0;
    end else begin
      case (state_q)
        S_GET_P: begin
          if (!p_ack_q) begin
            p_ack_q <= 1'b1;
          end else if (input_p_stb) begin
            p_q     <= input_p;
            p_ack_q <= 1'b0;
            state_q <= S_GET_L;
          end
        end
        S_GET_L: begin
          if (!l_ack_q) begin
            l_ack_q <= 1'b1;
          end else if (input_l_stb) begin
            l_q     <= {1'b0, input_l[30:0]};
            l_ack_q <= 1'b0;
            state_q <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          key_p_q  <= key_p_d;
          key_l_q  <= key_l_d;
          key_nl_q <= key_nl_d;
          nan_q    <= nan_d;
          state_q  <= S_COMPARE;
        end
        S_COMPARE: begin
          z_q       <= z_d;
          clipped_q <= clipped_d;
          z_stb_q   <= 1'b1;
          state_q   <= S_PUT_Z;
        end
        S_PUT_Z: begin
          if (output_z_ack) begin
            z_stb_q <= 1'b0;
            state_q <= S_GET_P;
          end
        end
        default: begin
          state_q <= S_GET_P;
        end
      endcase
    end
  end

  assign input_p_ack    = p_ack_q;
  assign input_l_ack    = l_ack_q;
  assign output_z       = z_q;
  assign output_clipped = clipped_q;
  assign output_z_stb   = z_stb_q;

endmodule

// File: doc/float_clamp.md
# float_clamp

Sequential IEEE-754 single-precision clamp stage for the `dCollideSphereBox` datapath. It takes one sphere-centre coordinate `p` (already expressed in box space) and the matching box half-extent `l`, and returns `clamp(p, -|l|, +|l|)` together with a `clipped` flag. The result feeds the distance stage that follows the sign/less-than comparator. It uses the same strobe/acknowledge handshake as the other float units in the collision pipeline.

## Interface
- No parameters; width fixed at 32 (binary32).
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `input_p` input 32 — coordinate to clamp.
- `input_p_stb` input 1 — `input_p` valid.
- `input_p_ack` output 1 — stage ready to take `input_p`.
- `input_l` input 32 — half-extent; the sign bit is ignored (|l| is used).
- `input_l_stb` input 1 — `input_l` valid.
- `input_l_ack` output 1 — stage ready to take `input_l`.
- `output_z` output 32 — clamped value.
- `output_clipped` output 1 — 1 when `p` lay outside [-|l|, +|l|].
- `output_z_stb` output 1 — `output_z` and `output_clipped` valid.
- `output_z_ack` input 1 — consumer accepts the result.

## Operation
- **State machine:** GET_P → GET_L → UNPACK → COMPARE → PUT_Z → GET_P.
- **GET_P:**
  - `input_p_ack` is registered to 1 on entry.
  - A transfer occurs on the first edge where `input_p_ack` and `input_p_stb` are both high.
  - On that edge `p` is latched, ack is cleared, and the state moves to GET_L.
- **GET_L:** same rule using `input_l`; the block latches `{1'b0, input_l[30:0]}`.
- **UNPACK:**
  - Detect NaN on each operand: exponent 255 with a nonzero mantissa.
  - Form order keys: for sign 0, `key = bits | 32'h8000_0000`; for sign 1, `key = ~bits`.
  - `-0` is canonicalised to `+0` before key formation, so `-0 == +0`.
  - `-|l|` is formed by setting the sign bit of `|l|`.
- **COMPARE (unsigned key compares, priority order):**
  1. `p` or `l` is NaN → `z = 32'hFFC0_0000`, `clipped = 0`.
  2. `key(p) > key(|l|)` → `z = |l|`, `clipped = 1`.
  3. `key(p) < key(-|l|)` → `z = -|l|`, `clipped = 1`.
  4. Otherwise → `z = p` (original bits, including `-0`), `clipped = 0`.
- **Infinities:** compared like any other value. `p = ±inf` with finite `l` clamps; `l = inf` passes every non-NaN `p` through.
- **PUT_Z:**
  - `output_z_stb` is 1; `output_z` and `output_clipped` hold stable.
  - On an edge with `output_z_ack = 1`, stb clears and the state returns to GET_P.
- **Reset:** `rst` high at any time, including mid-transaction:
  - state → GET_P;
  - every ack and stb output → 0;
  - `output_z` → 0, `output_clipped` → 0;
  - any partially latched operands are discarded.

## Timing
- Operands are taken serially, `p` first; an `l` strobe during GET_P is ignored.
- The ack rises one cycle after entering a GET state, so the minimum is 2 cycles per operand.
- Latency: `output_z_stb` is high 2 edges after the `input_l` transfer edge (UNPACK edge, then COMPARE edge).
- Minimum throughput: 1 result per 7 cycles with zero backpressure.
- Outputs are held for as many cycles as `output_z_ack` stays low; there is no timeout.
- `output_z_ack` asserted while `output_z_stb = 0` has no effect.
- Ack and strobe outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `float_pkg` holds:
  - `FP_QNAN = 32'hFFC0_0000`, `FP_EXP_MAX = 8'hFF`, `FP_SIGN_MASK = 32'h8000_0000`;
  - the state encoding (4-bit localparams);
  - function `fp_is_nan(bits)`.
- Sub-module `float_order_key`: combinational; takes the 32-bit float and returns the 32-bit unsigned key with zero canonicalisation. It is instantiated twice.
- All other logic lives in the `float_clamp` top.

## Test plan
- In range: `p = 0x3F00_0000` (0.5), `l = 0x3F80_0000` (1.0) → `z = 0x3F00_0000`, `clipped = 0`; stb appears 2 edges after the l transfer.
- Above range: `p = 0x4000_0000` (2.0), `l = 0xBF80_0000` (-1.0, sign ignored) → `z = 0x3F80_0000`, `clipped = 1`.
- Below range and infinity:
  - `p = 0xC040_0000` (-3.0), `l = 1.0` → `z = 0xBF80_0000`, `clipped = 1`;
  - `p = 0xFF80_0000` (-inf), `l = 1.0` → `z = 0xBF80_0000`, `clipped = 1`.
- Zeros and NaN:
  - `p = 0x8000_0000`, `l = 0x0000_0000` → `z = 0x8000_0000`, `clipped = 0`;
  - `p = 0x7FC0_0001` → `z = 0xFFC0_0000`, `clipped = 0`;
  - `l = 0x7F80_0000` (+inf), `p = 0x7F7F_FFFF` → `z = p`, `clipped = 0`.
- Backpressure: hold `output_z_ack` low 5 cycles → z, clipped and stb stable throughout; ack for 1 cycle → stb low on the next edge, `input_p_ack` high 1 cycle later.
- Reset mid-operation: assert `rst` asynchronously during GET_L and again during PUT_Z → all outputs 0 immediately; a following clean transaction (2.0, 1.0) produces `0x3F80_0000`.
